// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter that shares the register file's single access port between NUM_REQ requesters.
// Optional locked follow-on grants are enabled by defining REGFILE_ARB_LOCK_EN.
module regfile_port_arbiter #(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]        req_lock,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rf_en,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_addr,
    output logic [DATA_W-1:0]         rf_wdata,
    input  logic [DATA_W-1:0]         rf_rdata,
    output logic [1:0]                grant_id,
    output logic [7:0]                arb_error_vector
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e                    state_q, state_d;
    logic [1:0]                rr_ptr_q, rr_ptr_d;
    logic [1:0]                id_q;
    logic                      we_q;
    logic [ADDR_W-1:0]         addr_q;
    logic [DATA_W-1:0]         wdata_q;
    logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]         rsp_rdata_q;
    logic [2:0]                err_q, err_d;

    logic [NUM_REQ-1:0]        pend_q;
    logic [NUM_REQ-1:0]        prev_we_q;
    logic [NUM_REQ*ADDR_W-1:0] prev_addr_q;
    logic [NUM_REQ*DATA_W-1:0] prev_wdata_q;

    logic                      rr_found;
    logic [1:0]                rr_win;
    logic                      win_valid;
    logic [1:0]                winner;
    logic                      handshake;
    logic                      sel_we;
    logic                      sel_lock;
    logic [ADDR_W-1:0]         sel_addr;
    logic [DATA_W-1:0]         sel_wdata;
    logic                      x0_err;
    logic                      stab_err;
    logic                      lock_err;

    // Two passes: first from rr_ptr upward, then wrap to the indices below it.
    always_comb begin
        rr_found = 1'b0;
        rr_win   = '0;
        for (int j = 0; j < int'(NUM_REQ); j++) begin
            if (!rr_found && req_valid[j] && (2'(j) >= rr_ptr_q)) begin
                rr_found = 1'b1;
                rr_win   = 2'(j);
            end
        end
        for (int j = 0; j < int'(NUM_REQ); j++) begin
            if (!rr_found && req_valid[j] && (2'(j) < rr_ptr_q)) begin
                rr_found = 1'b1;
                rr_win   = 2'(j);
            end
        end
    end

`ifdef REGFILE_ARB_LOCK_EN
    localparam int unsigned CntW = $clog2(LOCK_MAX + 1);

    logic            lock_q, lock_d;
    logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
    logic            lock_hold;

    // The locked requester is always the one granted last, i.e. id_q.
    always_comb begin
        lock_hold = 1'b0;
        for (int j = 0; j < int'(NUM_REQ); j++) begin
            if (id_q == 2'(j)) begin
                lock_hold = lock_q && req_valid[j];
            end
        end
        win_valid = lock_hold ? 1'b1 : rr_found;
        winner    = lock_hold ? id_q : rr_win;
    end

    always_comb begin
        lock_d     = lock_q;
        lock_cnt_d = lock_cnt_q;
        lock_err   = 1'b0;
        if ((state_q == StIdle) && lock_q && !lock_hold) begin
            lock_d     = 1'b0;
            lock_cnt_d = '0;
        end
        if (handshake) begin
            if (!sel_lock) begin
                lock_d     = 1'b0;
                lock_cnt_d = '0;
            end else if (int'(lock_cnt_q) + 1 >= int'(LOCK_MAX)) begin
                lock_d     = 1'b0;
                lock_cnt_d = '0;
                lock_err   = 1'b1;
            end else begin
                lock_d     = 1'b1;
                lock_cnt_d = lock_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_q     <= 1'b0;
            lock_cnt_q <= '0;
        end else begin
            lock_q     <= lock_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end
`else
    logic unused_lock;

    assign unused_lock = ^{req_lock, sel_lock};
    assign win_valid   = rr_found;
    assign winner      = rr_win;
    assign lock_err    = 1'b0;
`endif

    assign handshake = rst && (state_q == StIdle) && win_valid;

    always_comb begin
        req_ready = '0;
        sel_we    = 1'b0;
        sel_lock  = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int j = 0; j < int'(NUM_REQ); j++) begin
            if (winner == 2'(j)) begin
                req_ready[j] = handshake;
                sel_we       = req_we[j];
                sel_lock     = req_lock[j];
                sel_addr     = req_addr[j*ADDR_W +: ADDR_W];
                sel_wdata    = req_wdata[j*DATA_W +: DATA_W];
            end
        end
    end

    // A stalled request (valid, not ready) must hold its payload into the next cycle.
    always_comb begin
        stab_err = 1'b0;
        for (int j = 0; j < int'(NUM_REQ); j++) begin
            if (pend_q[j] && req_valid[j] &&
                ((req_we[j] != prev_we_q[j]) ||
                 (req_addr[j*ADDR_W +: ADDR_W] != prev_addr_q[j*ADDR_W +: ADDR_W]) ||
                 (req_wdata[j*DATA_W +: DATA_W] != prev_wdata_q[j*DATA_W +: DATA_W]))) begin
                stab_err = 1'b1;
            end
        end
    end

    assign x0_err   = (state_q == StIssue) && we_q && (addr_q == '0);
    assign err_d    = err_q | {lock_err, stab_err, x0_err};
    assign rr_ptr_d = (winner == 2'(NUM_REQ - 1)) ? 2'd0 : winner + 2'd1;

    always_comb begin
        rsp_valid_d = '0;
        for (int j = 0; j < int'(NUM_REQ); j++) begin
            rsp_valid_d[j] = (state_q == StWait) && (id_q == 2'(j));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (handshake) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rf_en    = 1'b0;
        rf_we    = 1'b0;
        rf_addr  = '0;
        rf_wdata = '0;
        if (state_q == StIssue) begin
            rf_en    = 1'b1;
            rf_we    = we_q && (addr_q != '0);
            rf_addr  = addr_q;
            rf_wdata = wdata_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q     <= '0;
            id_q         <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            err_q        <= '0;
            pend_q       <= '0;
            prev_we_q    <= '0;
            prev_addr_q  <= '0;
            prev_wdata_q <= '0;
        end else begin
            if (handshake) begin
                rr_ptr_q <= rr_ptr_d;
                id_q     <= winner;
                we_q     <= sel_we;
                addr_q   <= sel_addr;
                wdata_q  <= sel_wdata;
            end
            if (state_q == StWait) begin
                rsp_rdata_q <= we_q ? '0 : rf_rdata;
            end
            rsp_valid_q  <= rsp_valid_d;
            err_q        <= err_d;
            pend_q       <= req_valid & ~req_ready;
            prev_we_q    <= req_we;
            prev_addr_q  <= req_addr;
            prev_wdata_q <= req_wdata;
        end
    end

    assign rsp_valid        = rsp_valid_q;
    assign rsp_rdata        = rsp_rdata_q;
    assign grant_id         = id_q;
    assign arb_error_vector = {5'b0, err_q};

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a small register file model.
// Define REGFILE_ARB_LOCK_EN to also exercise the lock feature.
module tb_regfile_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [9:0]  req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_lock;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rf_en;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata;
    logic [31:0] rf_rdata;
    logic [1:0]  grant_id;
    logic [7:0]  arb_error_vector;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [32];
    bit          written [32];

    regfile_port_arbiter #(
        .NUM_REQ (2),
        .ADDR_W  (5),
        .DATA_W  (32),
        .LOCK_MAX(8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_we          (req_we),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_lock        (req_lock),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .rf_en           (rf_en),
        .rf_we           (rf_we),
        .rf_addr         (rf_addr),
        .rf_wdata        (rf_wdata),
        .rf_rdata        (rf_rdata),
        .grant_id        (grant_id),
        .arb_error_vector(arb_error_vector)
    );

    always #5 clk = ~clk;

    // Unwritten locations read as A000_00aa, except x5 which holds DEADBEEF.
    function automatic logic [31:0] init_val(input logic [4:0] a);
        return (a == 5'd5) ? 32'hDEAD_BEEF : (32'hA000_0000 | 32'(a));
    endfunction

    always @(posedge clk) begin
        if (rf_en && rf_we) begin
            mem[rf_addr]     <= rf_wdata;
            written[rf_addr] <= 1'b1;
        end
        rf_rdata <= (rf_en && !rf_we) ? (written[rf_addr] ? mem[rf_addr] : init_val(rf_addr))
                                      : 32'h0;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic v, input logic we, input logic [4:0] a,
                           input logic [31:0] d);
        req_valid[r]         = v;
        req_we[r]            = we;
        req_addr[r*5 +: 5]   = a;
        req_wdata[r*32 +: 32] = d;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = 2'b11;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_lock  = '0;
        #3;
        check("rst_ready", 64'(req_ready), 64'(0));
        check("rst_rf_en", 64'(rf_en), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_err", 64'(arb_error_vector), 64'(0));
        check("rst_gid", 64'(grant_id), 64'(0));
        req_valid = '0;
        tick();
        tick();
        rst = 1'b1;

        // Single read of x5
        set_req(0, 1'b1, 1'b0, 5'd5, 32'h0);
        #1;
        check("t1_ready", 64'(req_ready), 64'(2'b01));
        tick();
        req_valid = '0;
        #1;
        check("t1_rf_en", 64'(rf_en), 64'(1));
        check("t1_rf_addr", 64'(rf_addr), 64'(5));
        check("t1_rf_we", 64'(rf_we), 64'(0));
        tick();
        #1;
        check("t1_wait_rsp", 64'(rsp_valid), 64'(0));
        tick();
        #1;
        check("t1_rsp_valid", 64'(rsp_valid), 64'(2'b01));
        check("t1_rsp_rdata", 64'(rsp_rdata), 64'(32'hDEAD_BEEF));
        check("t1_gid", 64'(grant_id), 64'(0));

        // Both requesters pending: 0,1,0,1 every 3 cycles
        do_reset();
        set_req(0, 1'b1, 1'b0, 5'd1, 32'h0);
        set_req(1, 1'b1, 1'b0, 5'd2, 32'h0);
        #1;
        for (int g = 0; g < 4; g++) begin
            logic [1:0] exp_oh;
            exp_oh = (g % 2 == 0) ? 2'b01 : 2'b10;
            check("rr_ready", 64'(req_ready), 64'(exp_oh));
            tick();
            if (g == 3) req_valid = '0;
            #1;
            check("rr_gid", 64'(grant_id), 64'(g % 2));
            check("rr_issue_ready", 64'(req_ready), 64'(0));
            check("rr_rf_addr", 64'(rf_addr), 64'((g % 2 == 0) ? 1 : 2));
            tick();
            #1;
            check("rr_wait_ready", 64'(req_ready), 64'(0));
            tick();
            #1;
            check("rr_rsp_valid", 64'(rsp_valid), 64'(exp_oh));
            check("rr_rsp_rdata", 64'(rsp_rdata),
                  64'((g % 2 == 0) ? 32'hA000_0001 : 32'hA000_0002));
        end

        // Write to x0 is suppressed and flagged, still acknowledged
        set_req(0, 1'b1, 1'b1, 5'd0, 32'h1234);
        #1;
        check("x0_ready", 64'(req_ready), 64'(2'b01));
        tick();
        req_valid = '0;
        #1;
        check("x0_rf_en", 64'(rf_en), 64'(1));
        check("x0_rf_we", 64'(rf_we), 64'(0));
        check("x0_rf_wdata", 64'(rf_wdata), 64'(32'h1234));
        tick();
        #1;
        check("x0_err", 64'(arb_error_vector), 64'(8'h01));
        tick();
        #1;
        check("x0_rsp_valid", 64'(rsp_valid), 64'(2'b01));
        check("x0_rsp_rdata", 64'(rsp_rdata), 64'(0));

        // Ordinary write from requester 1
        set_req(1, 1'b1, 1'b1, 5'd7, 32'hCAFE);
        #1;
        check("wr_ready", 64'(req_ready), 64'(2'b10));
        tick();
        req_valid = '0;
        #1;
        check("wr_rf_we", 64'(rf_we), 64'(1));
        check("wr_rf_addr", 64'(rf_addr), 64'(7));
        tick();
        tick();
        #1;
        check("wr_rsp_valid", 64'(rsp_valid), 64'(2'b10));

        // Requester 1 changes its address while stalled
        set_req(0, 1'b1, 1'b0, 5'd1, 32'h0);
        set_req(1, 1'b1, 1'b0, 5'd3, 32'h0);
        #1;
        check("st_ready0", 64'(req_ready), 64'(2'b01));
        tick();
        req_valid[0] = 1'b0;
        set_req(1, 1'b1, 1'b0, 5'd4, 32'h0);
        #1;
        tick();
        #1;
        check("st_err", 64'(arb_error_vector), 64'(8'h03));
        tick();
        #1;
        check("st_rsp0", 64'(rsp_valid), 64'(2'b01));
        check("st_ready1", 64'(req_ready), 64'(2'b10));
        tick();
        req_valid = '0;
        #1;
        check("st_rf_addr", 64'(rf_addr), 64'(4));
        tick();
        tick();
        #1;
        check("st_rsp1", 64'(rsp_valid), 64'(2'b10));
        check("st_rdata", 64'(rsp_rdata), 64'(32'hA000_0004));

        // Reset during ISSUE of a write discards it
        set_req(0, 1'b1, 1'b1, 5'd9, 32'h55);
        #1;
        check("ri_ready", 64'(req_ready), 64'(2'b01));
        tick();
        req_valid = '0;
        #1;
        check("ri_rf_we", 64'(rf_we), 64'(1));
        rst = 1'b0;
        #1;
        check("ri_rf_en", 64'(rf_en), 64'(0));
        check("ri_rf_we0", 64'(rf_we), 64'(0));
        check("ri_rf_addr", 64'(rf_addr), 64'(0));
        check("ri_rf_wdata", 64'(rf_wdata), 64'(0));
        check("ri_rdata", 64'(rsp_rdata), 64'(0));
        check("ri_err", 64'(arb_error_vector), 64'(0));
        tick();
        #1;
        check("ri_rsp_a", 64'(rsp_valid), 64'(0));
        tick();
        #1;
        check("ri_rsp_b", 64'(rsp_valid), 64'(0));
        rst = 1'b1;
        set_req(0, 1'b1, 1'b0, 5'd9, 32'h0);
        set_req(1, 1'b1, 1'b0, 5'd2, 32'h0);
        #1;
        check("ri_ready_after", 64'(req_ready), 64'(2'b01));
        tick();
        req_valid = '0;
        #1;
        check("ri_rf_addr9", 64'(rf_addr), 64'(9));
        tick();
        tick();
        #1;
        check("ri_rsp_after", 64'(rsp_valid), 64'(2'b01));
        check("ri_rdata_after", 64'(rsp_rdata), 64'(32'hA000_0009));

`ifdef REGFILE_ARB_LOCK_EN
        // Requester 0 holds lock: 8 grants, forced release, then requester 1
        do_reset();
        set_req(0, 1'b1, 1'b0, 5'd1, 32'h0);
        set_req(1, 1'b1, 1'b0, 5'd2, 32'h0);
        req_lock = 2'b01;
        #1;
        for (int g = 0; g < 8; g++) begin
            check("lk_ready0", 64'(req_ready), 64'(2'b01));
            tick();
            tick();
            tick();
            #1;
        end
        check("lk_err", 64'(arb_error_vector), 64'(8'h04));
        check("lk_ready1", 64'(req_ready), 64'(2'b10));
        tick();
        req_valid = '0;
        req_lock  = '0;
        tick();
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
